// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion and depth.
// Imported by both the read-side and write-side pointer blocks.
package fifo_rd_ctrl_pkg;

    localparam int PTR_MAX = 32;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = PTR_MAX - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into clk.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read side: write-pointer sync, empty detect, level, FWFT output.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ASIZE    = 4,
    parameter int WSIZE    = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   wptr_gray,
    input  logic [WSIZE-1:0] rdata_mem,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr_gray,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WSIZE-1:0] rd_data,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel,
    output logic             ralmost_empty
);

    localparam int DEPTH = fifo_depth(ASIZE);
    localparam int PW    = ASIZE + 1;

    generate
        if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
            $error("AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [ASIZE:0] wq2;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbin_nxt;
    logic [ASIZE:0] wbin;
    logic           mem_empty;
    logic           load;

    sync_2ff #(
        .W (PW)
    ) u_wsync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr_gray),
        .q   (wq2)
    );

    assign mem_empty = (rptr_gray == wq2);
    assign load      = !mem_empty && (!rd_valid || rd_ready);
    assign rbin_nxt  = rbin + PW'(load);
    assign wbin      = PW'(gray2bin(PTR_MAX'(wq2)));

    assign raddr         = rbin[ASIZE-1:0];
    assign rempty        = !rd_valid;
    assign ralmost_empty = (rlevel <= PW'(AE_LEVEL));

    // Gray and level both follow the post-edge rbin so they never lag a load.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rlevel    <= '0;
        end else begin
            rbin      <= rbin_nxt;
            rptr_gray <= PW'(bin2gray(PTR_MAX'(rbin_nxt)));
            rlevel    <= wbin - rbin_nxt;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= rdata_mem;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

endmodule
